// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier controller.
// Optional single-step mode is enabled by defining MULT_CTRL_STEP_EN.
package mult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_TEST  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4,
    ST_WAIT  = 3'd5
  } state_t;

  localparam int unsigned MULT_N = 4;

  // Bits needed to count iterations 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iter_counter.sv
// Iteration counter: clear to zero, increment on enable, saturate at N-1.
module iter_counter
  import mult_pkg::*;
#(
  parameter int unsigned N = MULT_N
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic term_c
);

  localparam int unsigned W = cnt_width(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  // Counter register; holds at LAST so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LAST)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign term_c = (cnt == LAST);

endmodule

// File: rtl/mult_control.sv
// Sequencer for the 4-bit shift-add multiplier: load, then one add-test and
// one shift per multiplier bit, then a level handshake on Fin.
// Define MULT_CTRL_STEP_EN to add the Step port and a WAIT state between
// iterations.
module mult_control
  import mult_pkg::*;
#(
  parameter int unsigned N = MULT_N
) (
  input  logic clk,
  input  logic ResetN,
  input  logic Start,
  input  logic Q0,
`ifdef MULT_CTRL_STEP_EN
  input  logic Step,
`endif
  output logic CargaA,
  output logic DesplazaA,
  output logic CargaB,
  output logic ClearP,
  output logic CargaP,
  output logic DesplazaP,
  output logic Busy,
  output logic Fin
);

  state_t state;
  state_t state_nxt;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_term;

  assign cnt_clr = (state == ST_LOAD);
  assign cnt_inc = (state == ST_SHIFT);

  iter_counter #(.N(N)) u_iter_counter (
    .clk    (clk),
    .rst_n  (ResetN),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .term_c (cnt_term)
  );

`ifdef MULT_CTRL_STEP_EN
  logic step_q;
  logic step_rise;

  // Previous Step level for rising-edge detection.
  always_ff @(posedge clk or negedge ResetN) begin
    if (!ResetN) begin
      step_q <= 1'b0;
    end else begin
      step_q <= Step;
    end
  end

  assign step_rise = Step & ~step_q;
`endif

  // Next-state decode; Start only matters in IDLE and DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (Start) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_TEST;
      ST_TEST:  state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (cnt_term) begin
          state_nxt = ST_DONE;
        end else begin
`ifdef MULT_CTRL_STEP_EN
          state_nxt = ST_WAIT;
`else
          state_nxt = ST_TEST;
`endif
        end
      end
      ST_DONE:  if (!Start) state_nxt = ST_IDLE;
`ifdef MULT_CTRL_STEP_EN
      ST_WAIT:  if (step_rise) state_nxt = ST_TEST;
`endif
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register and Moore outputs registered from the next state.
  always_ff @(posedge clk or negedge ResetN) begin
    if (!ResetN) begin
      state     <= ST_IDLE;
      CargaA    <= 1'b0;
      DesplazaA <= 1'b0;
      CargaB    <= 1'b0;
      ClearP    <= 1'b0;
      DesplazaP <= 1'b0;
      Busy      <= 1'b0;
      Fin       <= 1'b0;
    end else begin
      state     <= state_nxt;
      CargaA    <= (state_nxt == ST_LOAD);
      CargaB    <= (state_nxt == ST_LOAD);
      ClearP    <= (state_nxt == ST_LOAD);
      DesplazaA <= (state_nxt == ST_SHIFT);
      DesplazaP <= (state_nxt == ST_SHIFT);
      Busy      <= (state_nxt == ST_LOAD)  || (state_nxt == ST_TEST) ||
                   (state_nxt == ST_SHIFT) || (state_nxt == ST_WAIT);
      Fin       <= (state_nxt == ST_DONE);
    end
  end

  // Add decision uses the live LSB of A while in TEST.
  assign CargaP = (state == ST_TEST) & Q0;

endmodule

// File: tb/tb_mult_control.sv
// Self-checking bench for mult_control with a behavioural A/B/P datapath.
module tb_mult_control;

  localparam int unsigned N = 4;

  localparam logic [7:0] V_IDLE  = 8'b0000_0000;
  localparam logic [7:0] V_LOAD  = 8'b1011_0010;
  localparam logic [7:0] V_SHIFT = 8'b0100_0110;
  localparam logic [7:0] V_WAIT  = 8'b0000_0010;
  localparam logic [7:0] V_DONE  = 8'b0000_0001;

  logic clk = 1'b0;
  logic ResetN, Start, Q0, Step;
  logic CargaA, DesplazaA, CargaB, ClearP, CargaP, DesplazaP, Busy, Fin;

  logic [3:0] a_in, b_in, a_reg, b_reg, p_hi, p_lo;
  logic       carry;

  int checks = 0;
  int failures = 0;

  wire [7:0] ctl = {CargaA, DesplazaA, CargaB, ClearP, CargaP, DesplazaP, Busy, Fin};

  always #5 clk = ~clk;

  mult_control #(.N(N)) dut (
    .clk       (clk),
    .ResetN    (ResetN),
    .Start     (Start),
    .Q0        (Q0),
`ifdef MULT_CTRL_STEP_EN
    .Step      (Step),
`endif
    .CargaA    (CargaA),
    .DesplazaA (DesplazaA),
    .CargaB    (CargaB),
    .ClearP    (ClearP),
    .CargaP    (CargaP),
    .DesplazaP (DesplazaP),
    .Busy      (Busy),
    .Fin       (Fin)
  );

  // Behavioural datapath reacting to the controller's commands.
  always @(posedge clk) begin
    if (CargaA) a_reg <= a_in;
    else if (DesplazaA) a_reg <= a_reg >> 1;
    if (CargaB) b_reg <= b_in;
    if (ClearP) begin
      p_hi <= 4'd0; p_lo <= 4'd0; carry <= 1'b0;
    end else if (CargaP) begin
      {carry, p_hi} <= {1'b0, p_hi} + {1'b0, b_reg};
    end else if (DesplazaP) begin
      {p_hi, p_lo} <= {carry, p_hi, p_lo[3:1]};
      carry <= 1'b0;
    end
  end

  assign Q0 = a_reg[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One multiply; abort_k < N pulls reset during that iteration's SHIFT.
  task automatic run_mult(input logic [3:0] a, input logic [3:0] b,
                          input bit hold, input bit toggle, input int abort_k);
    a_in = a;
    b_in = b;
    @(negedge clk) Start = 1'b1;
    @(negedge clk) check("load", 32'(ctl), 32'(V_LOAD));
    Start = toggle ? 1'($urandom % 2) : hold;
    for (int k = 0; k < int'(N); k++) begin
      @(negedge clk) check($sformatf("test%0d", k), 32'(ctl), 32'({4'b0000, a[k], 3'b010}));
      Step = 1'b0;
      if (toggle) Start = 1'($urandom % 2);
      @(negedge clk) check($sformatf("shift%0d", k), 32'(ctl), 32'(V_SHIFT));
      if (toggle) Start = 1'($urandom % 2);
      if (k == abort_k) begin
        #2 ResetN = 1'b0;
        #1 check("rst_async", 32'(ctl), 32'(V_IDLE));
        Start = 1'b0;
        @(negedge clk) check("rst_hold", 32'(ctl), 32'(V_IDLE));
        ResetN = 1'b1;
        @(negedge clk) check("rst_idle", 32'(ctl), 32'(V_IDLE));
        return;
      end
      if (k == int'(N) - 1) Start = hold;
`ifdef MULT_CTRL_STEP_EN
      if (k != int'(N) - 1) begin
        int w;
        w = (k == 0) ? 6 : int'($urandom_range(1, 3));
        for (int j = 0; j < w; j++) begin
          @(negedge clk) check($sformatf("wait%0d", k), 32'(ctl), 32'(V_WAIT));
          if (toggle) Start = 1'($urandom % 2);
        end
        Step = 1'b1;
      end
`endif
    end
    @(negedge clk) check("fin", 32'(ctl), 32'(V_DONE));
    check("product", 32'({p_hi, p_lo}), 32'(a) * 32'(b));
    if (hold) begin
      for (int j = 0; j < 20; j++) begin
        @(negedge clk) check("fin_hold", 32'(ctl), 32'(V_DONE));
      end
    end
    Start = 1'b0;
    @(negedge clk) check("idle", 32'(ctl), 32'(V_IDLE));
  endtask

  initial begin
    ResetN = 1'b0;
    Start  = 1'b0;
    Step   = 1'b0;
    a_in = 4'd0; b_in = 4'd0; a_reg = 4'd0; b_reg = 4'd0;
    p_hi = 4'd0; p_lo = 4'd0; carry = 1'b0;
    #12 check("reset", 32'(ctl), 32'(V_IDLE));
    @(negedge clk) ResetN = 1'b1;
    @(negedge clk) check("idle0", 32'(ctl), 32'(V_IDLE));

    run_mult(4'b1011, 4'b0110, 1'b0, 1'b0, N);
    run_mult(4'b0000, 4'($urandom), 1'b0, 1'b0, N);
    run_mult(4'b1011, 4'b0110, 1'b0, 1'b0, 2);
    run_mult(4'b1011, 4'b0110, 1'b0, 1'b0, N);
    run_mult(4'($urandom), 4'($urandom), 1'b1, 1'b0, N);
    run_mult(4'b1111, 4'b1111, 1'b0, 1'b0, N);
    for (int i = 0; i < 8; i++) begin
      run_mult(4'($urandom), 4'($urandom), 1'b0, 1'b1, N);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
